// File: rtl/operand_sweeper_if.sv
// Operand/result bus between the sweeper and the comparator it drives.
// The sweeper presents A/B with valid; the comparator side returns ready and the 3-bit result P.
interface operand_sweeper_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] operand_sweeper_oport_A;
  logic [WIDTH-1:0] operand_sweeper_oport_B;
  logic             operand_sweeper_oport_valid;
  logic             operand_sweeper_port_ready;
  logic [2:0]       operand_sweeper_port_P;

  modport master (
    output operand_sweeper_oport_A,
    output operand_sweeper_oport_B,
    output operand_sweeper_oport_valid,
    input  operand_sweeper_port_ready,
    input  operand_sweeper_port_P
  );

  modport slave (
    input  operand_sweeper_oport_A,
    input  operand_sweeper_oport_B,
    input  operand_sweeper_oport_valid,
    output operand_sweeper_port_ready,
    output operand_sweeper_port_P
  );
endinterface

// File: rtl/operand_sweeper.sv
// Nested A/B operand sweep with valid/ready handshake; tallies comparator results
// and counts disagreements with an internally computed reference.
//
// state | meaning
// IDLE  | waiting for start, outputs at reset values
// RUN   | presenting pairs, one advance per handshake
// DONE  | sweep complete, operands and tallies held until next start
module operand_sweeper #(
  parameter int WIDTH = 4,
  parameter int A_MAX = 9,
  parameter int B_MAX = 9,
  parameter int CW    = 2*WIDTH+1
) (
  input  logic                 operand_sweeper_port_clk,
  input  logic                 operand_sweeper_port_rst,
  input  logic                 operand_sweeper_port_start,
  operand_sweeper_if.master    bus,
  output logic                 operand_sweeper_oport_busy,
  output logic                 operand_sweeper_oport_done,
  output logic [CW-1:0]        operand_sweeper_oport_gt_cnt,
  output logic [CW-1:0]        operand_sweeper_oport_eq_cnt,
  output logic [CW-1:0]        operand_sweeper_oport_lt_cnt,
  output logic [CW-1:0]        operand_sweeper_oport_mis_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [WIDTH-1:0] A_LAST  = WIDTH'(A_MAX);
  localparam logic [WIDTH-1:0] B_LAST  = WIDTH'(B_MAX);
  localparam logic [CW-1:0]    CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]    gt_q, gt_d, eq_q, eq_d, lt_q, lt_d, mis_q, mis_d;
  logic             hs;
  logic [2:0]       exp_p;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  assign hs    = valid_q & bus.operand_sweeper_port_ready;
  assign exp_p = {a_q > b_q, a_q == b_q, a_q < b_q};

  always_ff @(posedge operand_sweeper_port_clk) begin
    if (operand_sweeper_port_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= '0;
      eq_q    <= '0;
      lt_q    <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = done_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE, DONE: begin
        // Start from either idle state launches a fresh sweep with cleared tallies.
        if (operand_sweeper_port_start) begin
          state_d = RUN;
          a_d     = '0;
          b_d     = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          gt_d    = '0;
          eq_d    = '0;
          lt_d    = '0;
          mis_d   = '0;
        end
      end
      RUN: begin
        if (hs) begin
          if (bus.operand_sweeper_port_P == 3'b100) gt_d = sat_inc(gt_q);
          if (bus.operand_sweeper_port_P == 3'b010) eq_d = sat_inc(eq_q);
          if (bus.operand_sweeper_port_P == 3'b001) lt_d = sat_inc(lt_q);
          if (bus.operand_sweeper_port_P != exp_p)  mis_d = sat_inc(mis_q);
          if (b_q < B_LAST) begin
            b_d = b_q + WIDTH'(1);
          end else begin
            b_d = '0;
            if (a_q < A_LAST) begin
              a_d = a_q + WIDTH'(1);
            end else begin
              // Final pair keeps its operands on the outputs.
              b_d     = b_q;
              state_d = DONE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.operand_sweeper_oport_A     = a_q;
  assign bus.operand_sweeper_oport_B     = b_q;
  assign bus.operand_sweeper_oport_valid = valid_q;
  assign operand_sweeper_oport_busy      = busy_q;
  assign operand_sweeper_oport_done      = done_q;
  assign operand_sweeper_oport_gt_cnt    = gt_q;
  assign operand_sweeper_oport_eq_cnt    = eq_q;
  assign operand_sweeper_oport_lt_cnt    = lt_q;
  assign operand_sweeper_oport_mis_cnt   = mis_q;

endmodule

// File: doc/operand_sweeper.md
# operand_sweeper

Synchronous operand generator and result checker placed directly upstream of the `comparator` block. It steps operand pairs (A, B) through a nested sweep, presenting each pair with a valid/ready handshake. On each accepted pair it samples the comparator's 3-bit result P, tallies greater/equal/less outcomes, and counts results that disagree with its own internal comparison. This gives a synthesizable, self-checking replacement for a nested-loop stimulus process.

## Interface
Parameters:
- `WIDTH`, default 4: operand width, which matches the comparator port width.
- `A_MAX`, default 9: last A value of the sweep. A runs 0..A_MAX.
- `B_MAX`, default 9: last B value of the sweep. B runs 0..B_MAX.
- `CW`, default 2*WIDTH+1: width of every tally counter.

Ports:
- `operand_sweeper_port_clk`, input, 1: single clock. All logic is on the rising edge.
- `operand_sweeper_port_rst`, input, 1: synchronous, active-high reset.
- `operand_sweeper_port_start`, input, 1: one-cycle start request.
- `operand_sweeper_port_ready`, input, 1: downstream accepts the current pair.
- `operand_sweeper_port_P`, input, 3: comparator result. Encoding: P[2] means A>B, P[1] means A==B, P[0] means A<B.
- `operand_sweeper_oport_A`, output, WIDTH: operand A.
- `operand_sweeper_oport_B`, output, WIDTH: operand B.
- `operand_sweeper_oport_valid`, output, 1: the A/B pair is valid.
- `operand_sweeper_oport_busy`, output, 1: FSM is in RUN.
- `operand_sweeper_oport_done`, output, 1: sweep is complete. Held until the next start or reset.
- `operand_sweeper_oport_gt_cnt`, output, CW: number of accepted pairs with P==3'b100.
- `operand_sweeper_oport_eq_cnt`, output, CW: number of accepted pairs with P==3'b010.
- `operand_sweeper_oport_lt_cnt`, output, CW: number of accepted pairs with P==3'b001.
- `operand_sweeper_oport_mis_cnt`, output, CW: number of accepted pairs where P differs from the expected value.

## Operation
- Reset has priority over everything else. It sets state IDLE and clears all outputs to 0: A, B, valid, busy, done and all four counters.
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - valid=0 and busy=0; A and B are held at 0.
  - start=1 moves the FSM to RUN.
  - On that same edge: A=0, B=0, all counters cleared.
- **RUN**
  - valid=1 and busy=1.
  - A handshake occurs on an edge where valid=1 and ready=1.
  - Without a handshake, A, B and valid hold stable.
- **On a handshake**
  - Sample P.
  - Compute expected E = {A>B, A==B, A<B} from the current A and B.
  - If P==3'b100, increment gt_cnt. If P==3'b010, increment eq_cnt. If P==3'b001, increment lt_cnt. Any other P value increments no tally.
  - If P!=E, increment mis_cnt. This applies to non-one-hot P values too.
  - Advance the operands. If B<B_MAX, then B=B+1. Otherwise B=0, and then:
    - if A<A_MAX, A=A+1;
    - if A==A_MAX, go to DONE.
- **DONE**
  - valid=0, busy=0, done=1.
  - A and B hold their final values. Counters hold.
  - start=1 clears done and the counters, sets A=0 and B=0, and moves the FSM to RUN.
- start is ignored while in RUN.
- All counters saturate at 2^CW−1 and never wrap. With the default parameters saturation cannot occur: 100 pairs is well below 511.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- The start edge is edge N.
  - valid=1 with A=0, B=0 from edge N onward (visible in cycle N+1).
- Throughput with ready held at 1:
  - one pair per cycle;
  - counters reflect a handshake at edge K from cycle K+1;
  - the full sweep takes (A_MAX+1)·(B_MAX+1) cycles of valid.
- The last handshake edge L sets done=1 and clears valid and busy, visible from cycle L+1.
- P is sampled on the handshake edge. The comparator between oport_A/oport_B and port_P is combinational, so P corresponds to the presented pair in the same cycle.
- ready toggling changes only when a pair advances. The pair sequence never skips or repeats a value.
- If reset is asserted mid-RUN, the next cycle shows IDLE with all-zero outputs and no partial done.
- If start and reset are both high on the same edge, reset wins.

## Test plan
- **Default sweep, correct comparator, ready=1.** Pulse start. Expect:
  - exactly 100 valid cycles, with pairs ordered (0,0),(0,1)…(9,9);
  - done from the cycle after the 100th handshake;
  - gt=45, eq=10, lt=45, mis=0.
- **Backpressure.** Drop ready for 3 cycles while A=2, B=5. Expect:
  - A=2, B=5 and valid=1 held for all 3 cycles;
  - the next handshake advances to (2,6);
  - final counts unchanged: 45/10/45/0.
- **Stuck comparator.** Force P=3'b010 on every pair. Expect eq=100, gt=0, lt=0, mis=90.
- **Invalid encoding.** Force P=3'b000. Expect gt=eq=lt=0 and mis=100; done is still reached after 100 handshakes.
- **Reset mid-run.** Assert reset at pair (4,3). Expect:
  - on the next cycle: A=0, B=0, valid=0, busy=0, done=0, all counts 0;
  - a subsequent start runs a clean full sweep with counts 45/10/45/0.
- **Restart and ignore rules.**
  - start pulses during RUN have no effect on sequence or counts.
  - start in DONE clears done and the counts, and restarts at (0,0).
